// File: rtl/id_ex_pipe_pkg.sv
// Shared constants and payload layout for the ID/EX pipeline register.
// Ex-control bit positions plus the default-width beat struct.
package id_ex_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int WB_W_DEF    = 2;
    localparam int M_W_DEF     = 3;
    localparam int CNT_W_DEF   = 16;
    localparam int EX_W        = 4;

    localparam int REGDST_BIT  = 3;
    localparam int ALUOP_HI    = 2;
    localparam int ALUOP_LO    = 1;
    localparam int ALUSRC_BIT  = 0;

    typedef struct packed {
        logic [WB_W_DEF-1:0]    ctlwb;
        logic [M_W_DEF-1:0]     ctlm;
        logic [EX_W-1:0]        ctlex;
        logic [DATA_W_DEF-1:0]  npc;
        logic [DATA_W_DEF-1:0]  rdata1;
        logic [DATA_W_DEF-1:0]  rdata2;
        logic [DATA_W_DEF-1:0]  sext;
        logic [RADDR_W_DEF-1:0] rt;
        logic [RADDR_W_DEF-1:0] rd;
    } id_ex_beat_t;

    localparam int BEAT_W_DEF = $bits(id_ex_beat_t);

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID-side and EX-side handshake plus payload bundle of the ID/EX register.
// master = upstream/downstream environment view, slave = pipeline register view.
interface id_ex_pipe_if
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int WB_W    = WB_W_DEF,
    parameter int M_W     = M_W_DEF
) ();

    logic               in_valid;
    logic               in_ready;
    logic [WB_W-1:0]    ctlwb_in;
    logic [M_W-1:0]     ctlm_in;
    logic [EX_W-1:0]    ctlex_in;
    logic [DATA_W-1:0]  npc;
    logic [DATA_W-1:0]  readdat1;
    logic [DATA_W-1:0]  readdat2;
    logic [DATA_W-1:0]  signext;
    logic [RADDR_W-1:0] instr_2016;
    logic [RADDR_W-1:0] instr_1511;

    logic               out_valid;
    logic               out_ready;
    logic [WB_W-1:0]    wb_ctlout;
    logic [M_W-1:0]     m_ctlout;
    logic               regdst;
    logic               alusrc;
    logic [1:0]         aluop;
    logic [DATA_W-1:0]  npcout;
    logic [DATA_W-1:0]  rdata1out;
    logic [DATA_W-1:0]  rdata2out;
    logic [DATA_W-1:0]  s_extendout;
    logic [RADDR_W-1:0] instrout_2016;
    logic [RADDR_W-1:0] instrout_1511;

    modport master (
        output in_valid, ctlwb_in, ctlm_in, ctlex_in, npc, readdat1, readdat2,
               signext, instr_2016, instr_1511, out_ready,
        input  in_ready, out_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
               npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511
    );

    modport slave (
        input  in_valid, ctlwb_in, ctlm_in, ctlex_in, npc, readdat1, readdat2,
               signext, instr_2016, instr_1511, out_ready,
        output in_ready, out_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
               npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511
    );

endinterface

// File: rtl/id_ex_pipe_slot.sv
// Single payload register with load enable; control slice (MSBs) clearable on its own.
// Latency 1 cycle from ld_i; no handshake, the owner decides when to load.
module id_ex_slot
    import id_ex_pkg::*;
#(
    parameter int W     = 8,
    parameter int CTL_W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic         clr_ctl_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clearing the control slice wins over a load so a squash always leaves a bubble.
    always_comb begin
        q_d = q_q;
        if (clr_ctl_i) begin
            q_d[W-1 -: CTL_W] = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX elastic pipeline register with flush and saturating stall counter; ID_EX_SKID_EN adds a skid entry.
// Latency 1 cycle input transfer to out_valid; outputs come only from flops.
// Backpressure: base in_ready = !out_valid || out_ready; skid build in_ready = !skid_valid; flush forces in_ready.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int WB_W    = WB_W_DEF,
    parameter int M_W     = M_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    id_ex_pipe_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CTL_W = WB_W + M_W + EX_W;
    localparam int BW    = CTL_W + 4 * DATA_W + 2 * RADDR_W;

    logic [BW-1:0]    in_beat;
    logic [BW-1:0]    main_beat;
    logic [BW-1:0]    main_d;
    logic             main_ld;
    logic             out_vld_q;
    logic             out_vld_d;
    logic             out_xfer;
    logic [EX_W-1:0]  ex_ctl;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign in_beat  = {bus.ctlwb_in, bus.ctlm_in, bus.ctlex_in, bus.npc, bus.readdat1,
                       bus.readdat2, bus.signext, bus.instr_2016, bus.instr_1511};
    assign out_xfer = out_vld_q && bus.out_ready;

`ifdef ID_EX_SKID_EN
    logic          skid_vld_q;
    logic          skid_vld_d;
    logic          skid_ld;
    logic [BW-1:0] skid_beat;

    assign bus.in_ready = flush || !skid_vld_q;

    // A full skid implies a valid main beat; it drains into main on the next output transfer.
    always_comb begin
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        main_ld    = 1'b0;
        skid_ld    = 1'b0;
        main_d     = in_beat;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (bus.out_ready) begin
                main_ld    = 1'b1;
                main_d     = skid_beat;
                skid_vld_d = 1'b0;
            end
        end else if (bus.in_valid) begin
            if (!out_vld_q || bus.out_ready) begin
                main_ld   = 1'b1;
                out_vld_d = 1'b1;
            end else begin
                skid_ld    = 1'b1;
                skid_vld_d = 1'b1;
            end
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end
    end

    id_ex_slot #(.W(BW), .CTL_W(CTL_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_i      (skid_ld),
        .clr_ctl_i (1'b0),
        .d_i       (in_beat),
        .q_o       (skid_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q <= 1'b0;
        end else begin
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign bus.in_ready = flush || !out_vld_q || bus.out_ready;
    assign main_d       = in_beat;

    always_comb begin
        out_vld_d = out_vld_q;
        main_ld   = 1'b0;
        if (flush) begin
            out_vld_d = 1'b0;
        end else if (bus.in_valid && (!out_vld_q || bus.out_ready)) begin
            main_ld   = 1'b1;
            out_vld_d = 1'b1;
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end
    end
`endif

    id_ex_slot #(.W(BW), .CTL_W(CTL_W)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_i      (main_ld),
        .clr_ctl_i (flush),
        .d_i       (main_d),
        .q_o       (main_beat)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (out_vld_q && !bus.out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign {bus.wb_ctlout, bus.m_ctlout, ex_ctl, bus.npcout, bus.rdata1out, bus.rdata2out,
            bus.s_extendout, bus.instrout_2016, bus.instrout_1511} = main_beat;

    assign bus.regdst    = ex_ctl[REGDST_BIT];
    assign bus.aluop     = ex_ctl[ALUOP_HI:ALUOP_LO];
    assign bus.alusrc    = ex_ctl[ALUSRC_BIT];
    assign bus.out_valid = out_vld_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised, clocked successor to the ID/EX latch. Registers decoded control and operands between the ID and EX stages.
- Uses a valid/ready elastic handshake on both sides, with synchronous flush for branch/exception squash.
- Keeps a saturating back-pressure counter for performance debug.
- Sits between the decode/register-file stage and the ALU stage of the MIPS pipeline.

Parameters:
- DATA_W, 32, width of npc, readdat1, readdat2 and signext datapath fields
- RADDR_W, 5, register-address field width (rt/rd)
- WB_W, 2, write-back control field width
- M_W, 3, memory control field width
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of held and incoming beats
- in_valid  in  1  ID beat present
- in_ready  out  1  stage can accept this cycle
- ctlwb_in  in  WB_W  write-back controls
- ctlm_in  in  M_W  memory controls
- ctlex_in  in  4  {regdst, aluop[1:0], alusrc}
- npc, readdat1, readdat2, signext  in  DATA_W each  operands
- instr_2016, instr_1511  in  RADDR_W each  destination candidates
- out_valid  out  1  EX beat present
- out_ready  in  1  EX accepts
- wb_ctlout  out  WB_W
- m_ctlout  out  M_W
- regdst, alusrc  out  1 each
- aluop  out  2
- npcout, rdata1out, rdata2out, s_extendout  out  DATA_W each
- instrout_2016, instrout_1511  out  RADDR_W each
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every output register goes to 0, including out_valid and stall_cnt. in_ready reads 1 once reset deasserts.
- Output fields are driven only from flops; there is no combinational path from inputs to outputs.
- ctlex_in split: regdst=[3], aluop=[2:1], alusrc=[0].
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
- Base mode (no macro):
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - On input transfer, all fields are loaded and out_valid is set.
  - On output transfer without an input transfer, out_valid clears and the fields hold their values.
  - Simultaneous input and output transfer: the new beat replaces the old one and out_valid stays 1. Full throughput.
- Stall: out_valid=1 and out_ready=0 gives in_ready=0. Outputs hold bit-exact for any number of cycles.
- Flush (priority over everything except reset):
  - Next edge: out_valid cleared.
  - wb_ctlout, m_ctlout, regdst, aluop and alusrc are zeroed, forming a bubble.
  - Data fields are unchanged.
  - Any concurrent input beat is discarded.
  - in_ready is forced to 1 during flush, so upstream treats its beat as consumed.
- stall_cnt:
  - Increments each cycle out_valid && !out_ready.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset; flush does not clear it.
- Reset mid-stall: beat is lost, out_valid=0, counter=0.

Optional Feature:
- Macro: ID_EX_SKID_EN
- With the macro defined:
  - A one-entry skid register is added, and in_ready becomes a registered signal, in_ready = !skid_valid.
  - If the main register is held (stall) and an input transfer occurs, the beat goes to skid.
  - On the next output transfer, skid moves to main and skid_valid clears.
  - Order is preserved, and full throughput is kept with no out_ready→in_ready combinational path.
  - Flush clears skid_valid as well.
- Without the macro: base mode exactly as described above.

Decomposition:
- Package id_ex_pkg holds:
  - the ex-control bit positions (REGDST_BIT=3, ALUOP_HI=2, ALUOP_LO=1, ALUSRC_BIT=0);
  - a packed struct id_ex_beat_t bundling all payload fields;
  - the default widths.
- One sub-module is natural: id_ex_slot, a single payload register with load enable, used for the main register and for the skid register.

Test Plan:
- Reset then stream 4 beats with npc=0x100,0x104,0x108,0x10C and out_ready=1 → outputs appear 1 cycle later, back to back, out_valid continuous, stall_cnt=0.
- Hold out_ready=0 for 5 cycles while out_valid=1 (readdat1=0xDEADBEEF) → outputs are stable, in_ready=0 in base mode, and stall_cnt=5.
- Assert flush with in_valid=1 and ctlex_in=4'b1101 → next cycle out_valid=0, regdst/aluop/alusrc/wb/m all 0, and the input beat is never emitted.
- Simultaneous input and output transfer with npc 0x200→0x204 → out_valid stays 1 and npcout=0x204 one cycle later.
- With CNT_W=4, stall for 20 cycles → stall_cnt stops at 15 and never wraps.
- ID_EX_SKID_EN build: stall while sending 2 beats (A,B), then release → A then B are emitted in order, and in_ready falls only while skid is full.
